// File: rtl/riscv_top_unit.sv
// Single-cycle RV32I ALU execution core: decoder, 32-entry register file and ALU.
// One R-type or I-type ALU instruction executes per rising edge; the result is registered on rd.
module riscv_top_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] rd
);

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    logic [6:0]       opcode;
    logic [4:0]       rd_idx;
    logic [2:0]       funct3;
    logic [4:0]       rs1_idx;
    logic [4:0]       rs2_idx;
    logic [6:0]       funct7;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic [WIDTH-1:0] op_b;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] result;
    logic             valid;
    logic             use_imm;
    alu_op_e          alu_op;

    logic [WIDTH-1:0] regs_q [32];
    logic [WIDTH-1:0] regs_d [32];
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] rd_d;

    assign opcode  = addr[6:0];
    assign rd_idx  = addr[11:7];
    assign funct3  = addr[14:12];
    assign rs1_idx = addr[19:15];
    assign rs2_idx = addr[24:20];
    assign funct7  = addr[31:25];
    assign imm     = {{(WIDTH-12){addr[WIDTH-1]}}, addr[31:20]};

    assign rs1_val = (rs1_idx == 5'd0) ? '0 : regs_q[rs1_idx];
    assign rs2_val = (rs2_idx == 5'd0) ? '0 : regs_q[rs2_idx];
    assign op_b    = use_imm ? imm : rs2_val;
    assign shamt   = op_b[4:0];

    // Anything outside the listed funct7 encodings is treated as unsupported
    always_comb begin
        valid   = 1'b0;
        use_imm = 1'b0;
        alu_op  = ALU_ADD;
        if (opcode == OPC_R) begin
            case (funct3)
                3'd0: begin
                    valid  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    alu_op = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                end
                3'd1: begin valid = (funct7 == F7_BASE); alu_op = ALU_SLL;  end
                3'd2: begin valid = (funct7 == F7_BASE); alu_op = ALU_SLT;  end
                3'd3: begin valid = (funct7 == F7_BASE); alu_op = ALU_SLTU; end
                3'd4: begin valid = (funct7 == F7_BASE); alu_op = ALU_XOR;  end
                3'd5: begin
                    valid  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                end
                3'd6: begin valid = (funct7 == F7_BASE); alu_op = ALU_OR;   end
                default: begin valid = (funct7 == F7_BASE); alu_op = ALU_AND; end
            endcase
        end else if (opcode == OPC_I) begin
            use_imm = 1'b1;
            case (funct3)
                3'd0: begin valid = 1'b1; alu_op = ALU_ADD;  end
                3'd1: begin valid = (funct7 == F7_BASE); alu_op = ALU_SLL; end
                3'd2: begin valid = 1'b1; alu_op = ALU_SLT;  end
                3'd3: begin valid = 1'b1; alu_op = ALU_SLTU; end
                3'd4: begin valid = 1'b1; alu_op = ALU_XOR;  end
                3'd5: begin
                    valid  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                end
                3'd6: begin valid = 1'b1; alu_op = ALU_OR;   end
                default: begin valid = 1'b1; alu_op = ALU_AND; end
            endcase
        end
    end

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = rs1_val + op_b;
            ALU_SUB:  result = rs1_val - op_b;
            ALU_SLL:  result = rs1_val << shamt;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(rs1_val) < $signed(op_b))};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (rs1_val < op_b)};
            ALU_XOR:  result = rs1_val ^ op_b;
            ALU_SRL:  result = rs1_val >> shamt;
            ALU_SRA:  result = WIDTH'($signed(rs1_val) >>> shamt);
            ALU_OR:   result = rs1_val | op_b;
            ALU_AND:  result = rs1_val & op_b;
            default:  result = '0;
        endcase
    end

    // x0 is never written so its storage stays at the reset value of zero
    always_comb begin
        regs_d = regs_q;
        rd_d   = rd_q;
        if (valid) begin
            rd_d = result;
            if (rd_idx != 5'd0) begin
                regs_d[rd_idx] = result;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            regs_q <= regs_d;
            rd_q   <= rd_d;
        end
    end

    assign rd = rd_q;

endmodule

// File: tb/tb_riscv_top_unit.sv
// Self-checking bench for riscv_top_unit: directed literal sequences plus randomized
// instructions compared every cycle against an instruction-level model of the register file.
module tb_riscv_top_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] rd;

    riscv_top_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .rd   (rd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [31:0] m_regs [32];
    logic [31:0] m_rd;

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rdn);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rdn[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rdn);
        return {imm[11:0], rs1[4:0], f3[2:0], rdn[4:0], 7'h13};
    endfunction

    // Legality straight from the instruction table: only two opcodes, funct7 restricted per op
    function automatic bit model_legal(logic [31:0] ins);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = ins[31:25];
        f3 = ins[14:12];
        if (ins[6:0] == 7'h33)
            return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        if (ins[6:0] == 7'h13) begin
            if (f3 == 3'd1) return f7 == 7'h00;
            if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_result(logic [31:0] ins);
        logic [31:0] a;
        logic [31:0] b;
        int          sa;
        int          sb;
        int          sh;
        bit          alt;
        a  = m_regs[ins[19:15]];
        b  = (ins[6:0] == 7'h33) ? m_regs[ins[24:20]] : {{20{ins[31]}}, ins[31:20]};
        sa = a;
        sb = b;
        sh = int'(b[4:0]);
        alt = (ins[6:0] == 7'h33) ? (ins[31:25] == 7'h20)
                                  : (ins[14:12] == 3'd5 && ins[31:25] == 7'h20);
        case (ins[14:12])
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return (alt && a[31]) ? ~((~a) >> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
            m_rd <= 32'd0;
        end else if (model_legal(addr)) begin
            m_rd <= model_result(addr);
            if (addr[11:7] != 5'd0) m_regs[addr[11:7]] <= model_result(addr);
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en && !rst) begin
            checks++;
            if (rd !== m_rd) begin
                errors++;
                $display("[TB] FAIL cycle_cmp t=%0t instr=%08h rd=%08h expected=%08h",
                         $time, addr, rd, m_rd);
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] instr);
        @(negedge clk);
        addr = instr;
        @(posedge clk);
        #2;
    endtask

    task automatic check_output(input string name, input logic [31:0] exp);
        checks++;
        if (rd !== exp) begin
            errors++;
            $display("[TB] FAIL %s rd=%08h expected=%08h", name, rd, exp);
        end
        checks++;
        if (m_rd !== exp) begin
            errors++;
            $display("[TB] FAIL model_%s model=%08h expected=%08h", name, m_rd, exp);
        end
    endtask

    // Reads xN through ADDI x0,xN,0: result appears on rd, nothing is written
    task automatic read_reg(input int n, input logic [31:0] exp);
        apply_stimulus(enc_i(0, n, 0, 0));
        check_output($sformatf("read_x%0d", n), exp);
    endtask

    logic [31:0] seq_ins [11] = '{32'h00A08093, 32'h00A10113, 32'h001101B3, 32'h0030A233,
                                  32'h00115293, 32'h00211313, 32'h0032F3B3, 32'h0032E433,
                                  32'h0032C4B3, 32'h40610533, 32'h00000000};
    logic [31:0] seq_exp [11] = '{32'd10, 32'd10, 32'd20, 32'd1, 32'd5, 32'd40, 32'd4,
                                  32'd21, 32'd17, 32'hFFFFFFE2, 32'hFFFFFFE2};
    logic [31:0] reg_exp [11] = '{32'd0, 32'd10, 32'd10, 32'd20, 32'd1, 32'd5, 32'd40, 32'd4,
                                  32'd21, 32'd17, 32'hFFFFFFE2};

    initial begin
        rst  = 1'b0;
        addr = 32'd0;
        #2 rst = 1'b1;
        #1 check_output("reset_rd", 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;

        for (int n = 1; n <= 10; n++) read_reg(n, 32'd0);

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(seq_ins[i]);
            check_output($sformatf("seq_%0d", i), seq_exp[i]);
        end
        for (int n = 1; n <= 10; n++) read_reg(n, reg_exp[n]);

        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_output("async_reset", 32'd0);
        @(negedge clk);
        rst = 1'b0;
        read_reg(10, 32'd0);

        apply_stimulus(32'hFFF00093);               check_output("addi_m1", 32'hFFFFFFFF);
        apply_stimulus(enc_i(12'h404, 1, 5, 2));    check_output("srai_4", 32'hFFFFFFFF);
        apply_stimulus(enc_i(28, 1, 5, 3));         check_output("srli_28", 32'h0000000F);
        apply_stimulus(enc_r(0, 1, 0, 3, 4));       check_output("sltu", 32'd1);
        apply_stimulus(enc_r(0, 0, 1, 2, 5));       check_output("slt", 32'd1);

        apply_stimulus(enc_i(5, 0, 0, 0));          check_output("addi_x0", 32'd5);
        apply_stimulus(enc_r(0, 0, 0, 0, 1));       check_output("add_x0", 32'd0);

        apply_stimulus(enc_i(-1, 0, 0, 1));         check_output("wrap_m1", 32'hFFFFFFFF);
        apply_stimulus(enc_i(1, 1, 5, 1));          check_output("wrap_srli", 32'h7FFFFFFF);
        apply_stimulus(enc_i(1, 1, 0, 1));          check_output("wrap_add", 32'h80000000);
        apply_stimulus(enc_r(1, 1, 1, 0, 2));       check_output("illegal_f7", 32'h80000000);

        for (int it = 0; it < 600; it++) begin
            int          k;
            int          f3;
            int          f7;
            logic [11:0] imm;
            logic [31:0] w;
            k  = $urandom_range(0, 9);
            f3 = $urandom_range(0, 7);
            if (k < 4) begin
                case ($urandom_range(0, 5))
                    4:       f7 = 32'h20;
                    5:       f7 = 32'h01;
                    default: f7 = 0;
                endcase
                w = enc_r(f7, $urandom_range(0, 7), $urandom_range(0, 7), f3, $urandom_range(0, 7));
            end else if (k < 8) begin
                imm = 12'($urandom_range(0, 4095));
                if (f3 == 1) imm[11:5] = 7'h00;
                if (f3 == 5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                w = enc_i(int'(imm), $urandom_range(0, 7), f3, $urandom_range(0, 7));
            end else if (k == 8) begin
                w = $urandom;
                if (w[6:0] == 7'h13 || w[6:0] == 7'h33) w[6:0] = 7'h03;
            end else begin
                w = 32'd0;
            end
            apply_stimulus(w);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
